// File: rtl/snake_pkg.sv
// Shared snake board definitions: cell codes, board geometry and the
// arbiter state encoding used by the playfield memory arbiter.
package snake_pkg;

   localparam int BOARD_X = 64;
   localparam int BOARD_Y = 32;
   localparam int DEPTH   = BOARD_X * BOARD_Y;
   localparam int ADDR_W  = 11;
   localparam int DATA_W  = 2;

   localparam logic [DATA_W-1:0] CELL_EMPTY = 2'd0;
   localparam logic [DATA_W-1:0] CELL_SNAKE = 2'd1;
   localparam logic [DATA_W-1:0] CELL_COIN  = 2'd2;
   localparam logic [DATA_W-1:0] CELL_WALL  = 2'd3;

   typedef enum logic {
      ST_SERVE = 1'b0,
      ST_CLEAR = 1'b1
   } arb_state_t;

endpackage

// File: rtl/board_ram.sv
// Single-port playfield cell RAM: registered read, write-first, no reset,
// shaped so synthesis maps it onto block RAM.
module board_ram #(
   parameter int ADDR_W = 11,
   parameter int DATA_W = 2,
   parameter int DEPTH  = 2048
) (
   input  logic              clk,
   input  logic              we,
   input  logic [ADDR_W-1:0] addr,
   input  logic [DATA_W-1:0] wdata,
   output logic [DATA_W-1:0] rdata
);

   logic [DATA_W-1:0] mem [DEPTH];

   // One access per cycle; a write also returns the new data on rdata.
   always_ff @(posedge clk) begin
      if (we) begin
         mem[addr] <= wdata;
         rdata     <= wdata;
      end else begin
         rdata <= mem[addr];
      end
   end

endmodule

// File: rtl/board_mem_arbiter.sv
// Playfield memory arbiter: shares the single board RAM port between the
// VGA read path, the game update logic and the board clear engine.
module board_mem_arbiter #(
   parameter int                        ADDR_W      = snake_pkg::ADDR_W,
   parameter int                        DATA_W      = snake_pkg::DATA_W,
   parameter int                        DEPTH       = snake_pkg::DEPTH,
   parameter int                        MAX_WAIT    = 4,
   parameter logic [DATA_W-1:0]         CLEAR_VALUE = '0
) (
   input  logic              mclk,
   input  logic              reset,
   input  logic              vid_req,
   input  logic [ADDR_W-1:0] vid_addr,
   output logic [DATA_W-1:0] vid_data,
   output logic              vid_valid,
   output logic              vid_miss,
   input  logic              game_req,
   input  logic              game_we,
   input  logic [ADDR_W-1:0] game_addr,
   input  logic [DATA_W-1:0] game_wdata,
   output logic              game_gnt,
   output logic [DATA_W-1:0] game_rdata,
   output logic              game_rvalid,
   input  logic              clear_start,
   output logic              busy,
   output logic              clear_done
);

   import snake_pkg::*;

   localparam int                WAIT_W    = $clog2(MAX_WAIT + 1);
   localparam logic [WAIT_W-1:0] WAIT_SAT  = WAIT_W'(MAX_WAIT);
   localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

   arb_state_t        state;
   logic [ADDR_W-1:0] clr_addr;
   logic [WAIT_W-1:0] wait_cnt;

   logic              in_serve;
   logic              forced;
   logic              vid_acc;
   logic              clr_wr;

   logic              ram_we;
   logic [ADDR_W-1:0] ram_addr;
   logic [DATA_W-1:0] ram_wdata;
   logic [DATA_W-1:0] ram_rdata;

   logic [DATA_W-1:0] vid_data_q;
   logic [DATA_W-1:0] game_rdata_q;

   // A starved game request takes the slot even over video; otherwise video
   // always wins, and the sweep or the game only get the port when it is idle.
   assign in_serve = (state == ST_SERVE);
   assign forced   = in_serve & game_req & (wait_cnt == WAIT_SAT);
   assign game_gnt = in_serve & game_req & (forced | ~vid_req);
   assign vid_acc  = vid_req & ~forced;
   assign clr_wr   = (state == ST_CLEAR) & ~vid_req;
   assign busy     = (state == ST_CLEAR);

   // The RAM read port is shared, so each reader keeps its last value while
   // its own valid is low.
   assign vid_data   = vid_valid   ? ram_rdata : vid_data_q;
   assign game_rdata = game_rvalid ? ram_rdata : game_rdata_q;

   // Steer the single RAM port to whichever user owns this cycle.
   always_comb begin
      ram_we    = 1'b0;
      ram_addr  = vid_addr;
      ram_wdata = game_wdata;
      if (game_gnt) begin
         ram_we    = game_we;
         ram_addr  = game_addr;
         ram_wdata = game_wdata;
      end else if (clr_wr) begin
         ram_we    = 1'b1;
         ram_addr  = clr_addr;
         ram_wdata = CLEAR_VALUE;
      end
   end

   // Clear FSM and starvation counter; a fresh clear_start always restarts
   // the sweep at cell 0 and suppresses completion of an aborted sweep.
   always_ff @(posedge mclk or negedge reset) begin
      if (!reset) begin
         state      <= ST_CLEAR;
         clr_addr   <= '0;
         wait_cnt   <= '0;
         clear_done <= 1'b0;
      end else begin
         clear_done <= 1'b0;
         if (clear_start) begin
            state    <= ST_CLEAR;
            clr_addr <= '0;
         end else if (clr_wr) begin
            if (clr_addr == LAST_ADDR) begin
               state      <= ST_SERVE;
               clr_addr   <= '0;
               clear_done <= 1'b1;
            end else begin
               clr_addr <= clr_addr + 1'b1;
            end
         end
         if (in_serve && game_req && !game_gnt && !clear_start) begin
            if (wait_cnt != WAIT_SAT) begin
               wait_cnt <= wait_cnt + 1'b1;
            end
         end else begin
            wait_cnt <= '0;
         end
      end
   end

   // Read-valid strobes and held read data for both readers.
   always_ff @(posedge mclk or negedge reset) begin
      if (!reset) begin
         vid_valid    <= 1'b0;
         vid_miss     <= 1'b0;
         game_rvalid  <= 1'b0;
         vid_data_q   <= '0;
         game_rdata_q <= '0;
      end else begin
         vid_valid    <= vid_acc;
         vid_miss     <= vid_req & forced;
         game_rvalid  <= game_gnt & ~game_we;
         vid_data_q   <= vid_data;
         game_rdata_q <= game_rdata;
      end
   end

   board_ram #(
      .ADDR_W (ADDR_W),
      .DATA_W (DATA_W),
      .DEPTH  (DEPTH)
   ) u_ram (
      .clk   (mclk),
      .we    (ram_we),
      .addr  (ram_addr),
      .wdata (ram_wdata),
      .rdata (ram_rdata)
   );

endmodule
